// File: rtl/decode_pkg.sv
// +----------------------------------------------------------------------------+
// | decode_pkg: opcodes, control-bundle types and immediate helper for ID      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10
  } a_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    a_sel_t  a_sel;
    wb_sel_t wb_sel;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    ctrl_t       ctrl;
    logic        illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic [31:0] gen_imm(input imm_fmt_t fmt, input logic [31:0] ins);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// +----------------------------------------------------------------------------+
// | reg_file: 32-entry 2R1W register file, x0 hardwired, optional WB bypass    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_file #(
  parameter int XLEN      = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  localparam bit BYP = (BYPASS_EN != 0);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && rd_addr != 5'd0) regs_d[rd_addr] = rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass makes a same-cycle writeback visible before it lands in the array.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == 5'd0)                        rs1_data = '0;
    else if (BYP && we && rd_addr == rs1_addr)   rs1_data = rd_data;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == 5'd0)                        rs2_data = '0;
    else if (BYP && we && rd_addr == rs2_addr)   rs2_data = rd_data;
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +----------------------------------------------------------------------------+
// | decode_stage: RV32I ID stage - decode, regfile read, load-use stall, ID/EX |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     instruction_in,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [31:0]     id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [31:0]     id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output ctrl_t           id_ex_ctrl,
  output logic            id_ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  ctrl_t           ctrl;
  imm_fmt_t        imm_fmt;
  logic            illegal;
  logic            rs1_used;
  logic            rs2_used;
  logic            hz;
  id_ex_t          id_ex_d;
  id_ex_t          id_ex_q;

  assign opcode = instruction_in[6:0];
  assign rd     = instruction_in[11:7];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];

  reg_file #(
    .XLEN      (XLEN),
    .BYPASS_EN (BYPASS_EN)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .rd_addr  (wb_rd),
    .rd_data  (wb_data)
  );

  always_comb begin
    ctrl     = CTRL_NOP;
    imm_fmt  = IMM_NONE;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ITYPE;
        imm_fmt  = IMM_I;
        rs1_used = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        imm_fmt  = IMM_I;
        rs1_used = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_fmt  = IMM_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_BRANCH;
        imm_fmt  = IMM_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.a_sel     = A_PC;
        ctrl.wb_sel    = WB_PC4;
        imm_fmt = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.a_sel     = A_RS1;
        ctrl.wb_sel    = WB_PC4;
        imm_fmt  = IMM_I;
        rs1_used = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.a_sel     = A_ZERO;
        imm_fmt = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.a_sel     = A_PC;
        imm_fmt = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A wrong-path instruction being flushed must never hold the front end.
  assign hz = id_ex_q.ctrl.mem_read && (id_ex_q.rd != 5'd0) &&
              ((rs1_used && rs1 == id_ex_q.rd) || (rs2_used && rs2 == id_ex_q.rd));
  assign stall = hz && !flush;

  always_comb begin
    id_ex_d = ID_EX_BUBBLE;
    if (!(flush || stall)) begin
      id_ex_d.pc       = pc_in;
      id_ex_d.rs1_data = rs1_data;
      id_ex_d.rs2_data = rs2_data;
      id_ex_d.imm      = gen_imm(imm_fmt, instruction_in);
      id_ex_d.rs1      = rs1;
      id_ex_d.rs2      = rs2;
      id_ex_d.rd       = rd;
      id_ex_d.funct3   = instruction_in[14:12];
      id_ex_d.funct7b5 = instruction_in[30];
      id_ex_d.ctrl     = ctrl;
      id_ex_d.illegal  = illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= ID_EX_BUBBLE;
    else     id_ex_q <= id_ex_d;
  end

  assign id_ex_pc       = id_ex_q.pc;
  assign id_ex_rs1_data = id_ex_q.rs1_data;
  assign id_ex_rs2_data = id_ex_q.rs2_data;
  assign id_ex_imm      = id_ex_q.imm;
  assign id_ex_rs1      = id_ex_q.rs1;
  assign id_ex_rs2      = id_ex_q.rs2;
  assign id_ex_rd       = id_ex_q.rd;
  assign id_ex_funct3   = id_ex_q.funct3;
  assign id_ex_funct7b5 = id_ex_q.funct7b5;
  assign id_ex_ctrl     = id_ex_q.ctrl;
  assign id_ex_illegal  = id_ex_q.illegal;

endmodule

`default_nettype wire
